// File: rtl/bitonic_merge_ctrl.sv
// bitonic_merge_ctrl: issue sequencer for one bitonic merge node.
// Merges two pre-sorted head-tuple streams (A, B) into one sorted stream.
// Issue is gated on downstream credits. In-flight tuples are tracked
// through the NET_LAT-deep network so the last output and done can be flagged.
// Ports: i_clk/i_rst (async, active-high), i_start, A/B heads
//   (valid/last/top) with o_a_deq/o_b_deq, o_sel/o_issue/o_stall/
//   o_switch_output, i_credit_ret, o_out_valid/o_out_last,
//   o_busy/o_done/o_err, o_perf_issued/o_perf_stall.
// Optional macro BITONIC_MERGE_CTRL_PERF_EN enables the perf counters;
//   when it is undefined, both perf ports are tied to 0.
module bitonic_merge_ctrl #(
  parameter int W       = 32,
  parameter int NET_LAT = 2,
  parameter int CREDITS = 8,
  parameter int CW      = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_a_valid,
  input  logic         i_a_last,
  input  logic [W-1:0] i_a_top,
  output logic         o_a_deq,
  input  logic         i_b_valid,
  input  logic         i_b_last,
  input  logic [W-1:0] i_b_top,
  output logic         o_b_deq,
  output logic         o_sel,
  output logic         o_issue,
  output logic         o_stall,
  output logic         o_switch_output,
  input  logic         i_credit_ret,
  output logic         o_out_valid,
  output logic         o_out_last,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err,
  output logic [31:0]  o_perf_issued,
  output logic [31:0]  o_perf_stall
);

  typedef enum logic [2:0] {
    S_IDLE, S_MERGE, S_DRAIN_A, S_DRAIN_B, S_FLUSH
  } state_t;

  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  state_t        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          prev_q, prev_d;
  logic          a_fin_q, a_fin_d;
  logic          b_fin_q, b_fin_d;
  logic          err_q, err_d;
  logic          a_deq_q, b_deq_q, sel_q, issue_q;
  logic          stall_q, sw_q, busy_q, done_q, tag_q;
  logic          issue_d, src_d, tag_d, done_d, stall_d;
  logic [NET_LAT-1:0] vld_q, lst_q;
  logic          a_ok, b_ok, has_cr;

  // A head whose pop is still pending is stale until the FIFO refills.
  assign a_ok   = i_a_valid & ~a_deq_q & ~a_fin_q;
  assign b_ok   = i_b_valid & ~b_deq_q & ~b_fin_q;
  // A credit returned this cycle can be spent on the same edge.
  assign has_cr = (credit_q != '0) | i_credit_ret;

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    a_fin_d = a_fin_q;
    b_fin_d = b_fin_q;
    issue_d = 1'b0;
    src_d   = 1'b0;
    tag_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: if (i_start) begin
        state_d = S_MERGE;
        a_fin_d = 1'b0;
        b_fin_d = 1'b0;
        prev_d  = 1'b0;
      end
      S_MERGE: if (a_ok && b_ok && has_cr) begin
        issue_d = 1'b1;
        src_d   = i_b_top < i_a_top;
        if (src_d && i_b_last) begin
          b_fin_d = 1'b1;
          state_d = S_DRAIN_A;
        end else if (!src_d && i_a_last) begin
          a_fin_d = 1'b1;
          state_d = S_DRAIN_B;
        end
      end
      S_DRAIN_A: if (a_ok && has_cr) begin
        issue_d = 1'b1;
        if (i_a_last) begin
          a_fin_d = 1'b1;
          tag_d   = 1'b1;
          state_d = S_FLUSH;
        end
      end
      S_DRAIN_B: if (b_ok && has_cr) begin
        issue_d = 1'b1;
        src_d   = 1'b1;
        if (i_b_last) begin
          b_fin_d = 1'b1;
          tag_d   = 1'b1;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: if (o_out_last) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (issue_d) prev_d = src_d;

    stall_d = !issue_d && (state_d == S_MERGE ||
      state_d == S_DRAIN_A || state_d == S_DRAIN_B);

    credit_d = credit_q;
    err_d    = err_q;
    if (issue_d && !i_credit_ret) begin
      credit_d = credit_q - CW'(1);
    end else if (!issue_d && i_credit_ret) begin
      if (credit_q == CRED_MAX) err_d = 1'b1;
      else credit_d = credit_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      credit_q <= CRED_MAX;
      prev_q   <= 1'b0;
      a_fin_q  <= 1'b0;
      b_fin_q  <= 1'b0;
      err_q    <= 1'b0;
      a_deq_q  <= 1'b0;
      b_deq_q  <= 1'b0;
      sel_q    <= 1'b0;
      issue_q  <= 1'b0;
      stall_q  <= 1'b0;
      sw_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tag_q    <= 1'b0;
      vld_q    <= '0;
      lst_q    <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      prev_q   <= prev_d;
      a_fin_q  <= a_fin_d;
      b_fin_q  <= b_fin_d;
      err_q    <= err_d;
      a_deq_q  <= issue_d & ~src_d;
      b_deq_q  <= issue_d & src_d;
      sel_q    <= issue_d & src_d;
      issue_q  <= issue_d;
      stall_q  <= stall_d;
      sw_q     <= issue_d & (src_d != prev_q);
      busy_q   <= state_d != S_IDLE;
      done_q   <= done_d;
      tag_q    <= tag_d;
      // Shift in the registered issue so the output lags o_issue by NET_LAT.
      vld_q    <= NET_LAT'({vld_q, issue_q});
      lst_q    <= NET_LAT'({lst_q, issue_q & tag_q});
    end
  end

  assign o_a_deq         = a_deq_q;
  assign o_b_deq         = b_deq_q;
  assign o_sel           = sel_q;
  assign o_issue         = issue_q;
  assign o_stall         = stall_q;
  assign o_switch_output = sw_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_err           = err_q;
  assign o_out_valid     = vld_q[NET_LAT-1];
  assign o_out_last      = lst_q[NET_LAT-1];

`ifdef BITONIC_MERGE_CTRL_PERF_EN
  logic [31:0] perf_iss_q, perf_stl_q;
  logic        pass_start;

  assign pass_start = (state_q == S_IDLE) && i_start;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      perf_iss_q <= '0;
      perf_stl_q <= '0;
    end else if (pass_start) begin
      perf_iss_q <= '0;
      perf_stl_q <= 32'(stall_d);
    end else begin
      if (issue_d && perf_iss_q != '1) perf_iss_q <= perf_iss_q + 32'd1;
      if (stall_d && perf_stl_q != '1) perf_stl_q <= perf_stl_q + 32'd1;
    end
  end

  assign o_perf_issued = perf_iss_q;
  assign o_perf_stall  = perf_stl_q;
`else
  assign o_perf_issued = '0;
  assign o_perf_stall  = '0;
`endif

endmodule

// File: tb/tb_bitonic_merge_ctrl.sv
// tb_bitonic_merge_ctrl: directed and random merge passes checked against
// a stable two-list merge model, a credit-count model and an issue-time log.
`timescale 1ns/1ps
module tb_bitonic_merge_ctrl;
  localparam int W  = 32;
  localparam int NL = 2;
  localparam int CR = 8;

  logic         clk = 1'b0;
  logic         i_rst = 1'b0, i_start = 1'b0;
  logic         i_a_valid = 1'b0, i_a_last = 1'b0;
  logic [W-1:0] i_a_top = '0;
  logic         i_b_valid = 1'b0, i_b_last = 1'b0;
  logic [W-1:0] i_b_top = '0;
  logic         i_credit_ret = 1'b0;
  logic         o_a_deq, o_b_deq, o_sel, o_issue, o_stall, o_sw;
  logic         o_out_valid, o_out_last, o_busy, o_done, o_err;
  logic [31:0]  o_perf_issued, o_perf_stall;

  always #5 clk = ~clk;

  bitonic_merge_ctrl #(.W(W), .NET_LAT(NL), .CREDITS(CR), .CW(4)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
    .i_a_valid(i_a_valid), .i_a_last(i_a_last), .i_a_top(i_a_top),
    .o_a_deq(o_a_deq),
    .i_b_valid(i_b_valid), .i_b_last(i_b_last), .i_b_top(i_b_top),
    .o_b_deq(o_b_deq),
    .o_sel(o_sel), .o_issue(o_issue), .o_stall(o_stall),
    .o_switch_output(o_sw), .i_credit_ret(i_credit_ret),
    .o_out_valid(o_out_valid), .o_out_last(o_out_last),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_perf_issued(o_perf_issued), .o_perf_stall(o_perf_stall)
  );

  int n_pass = 0, n_tot = 0, n_fail = 0;
  int unsigned qa[$], qb[$];
  int ai, bi;
  int cr_m;
  bit err_m;
  bit ret_prev;
  logic [1023:0] iss_at;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_heads(input bit b_en);
    i_a_valid = ai < qa.size();
    i_a_top   = i_a_valid ? qa[ai] : '0;
    i_a_last  = i_a_valid && (ai == qa.size() - 1);
    i_b_valid = b_en && (bi < qb.size());
    i_b_top   = i_b_valid ? qb[bi] : '0;
    i_b_last  = i_b_valid && (bi == qb.size() - 1);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_start = 1'b0;
    i_credit_ret = 1'b0;
    @(posedge clk); #1;
    i_rst = 1'b0;
    cr_m = CR;
    err_m = 1'b0;
    ret_prev = 1'b0;
  endtask

  task automatic gen(input int na, input int nb);
    int unsigned v;
    qa.delete(); qb.delete();
    v = $urandom_range(0, 5);
    for (int i = 0; i < na; i++) begin v += $urandom_range(0, 3); qa.push_back(v); end
    v = $urandom_range(0, 5);
    for (int i = 0; i < nb; i++) begin v += $urandom_range(0, 3); qb.push_back(v); end
  endtask

  // ret_mode 0: return a credit every allowed cycle; 1: random returns.
  task automatic run_pass(input int ret_mode, input int ret_start,
                          input int b_hold, input int starve_c);
    int exp_src[$];
    int i, j, n, k, c, first_iss, resume, ol_c, last_iss_c;
    bit prev, fin, ret, exp_ov, exp_ol;
    i = 0; j = 0;
    while (i < qa.size() || j < qb.size()) begin
      if (i < qa.size() && (j >= qb.size() || qa[i] <= qb[j])) begin
        exp_src.push_back(0); i++;
      end else begin
        exp_src.push_back(1); j++;
      end
    end
    n = exp_src.size();
    k = 0; prev = 0; fin = 0; first_iss = -1; resume = -1;
    ol_c = -1; last_iss_c = -1; iss_at = '0;
    ai = 0; bi = 0;
    i_start = 1'b1;
    drive_heads(b_hold <= 0);
    for (c = 0; c < 600 && !fin; c++) begin
      @(posedge clk); #1;
      if (c == 0) chk("busy_start", o_busy, 1);
      if (o_issue) begin
        chk("issue_in_range", k < n, 1);
        if (k < n) begin
          chk("sel", o_sel, exp_src[k]);
          chk("switch", o_sw, exp_src[k] != prev);
          prev = exp_src[k] != 0;
        end
        chk("deq", {o_a_deq, o_b_deq}, o_sel ? 2'b01 : 2'b10);
        chk("deq_valid", o_b_deq ? i_b_valid : i_a_valid, 1);
        chk("credit_avail", (cr_m + ret_prev) > 0, 1);
        iss_at[c] = 1'b1;
        if (first_iss < 0) first_iss = c;
        if (starve_c >= 0 && c > starve_c && resume < 0) resume = c;
        k++;
        if (k == n) last_iss_c = c;
        if (o_a_deq) ai++;
        if (o_b_deq) bi++;
      end else begin
        chk("deq_idle", {o_a_deq, o_b_deq}, 2'b00);
      end
      chk("stall", o_stall, !o_issue && k < n);
      exp_ov = c >= NL && iss_at[c-NL];
      exp_ol = exp_ov && (c - NL == last_iss_c);
      chk("out_valid", o_out_valid, exp_ov);
      chk("out_last", o_out_last, exp_ol);
      if (exp_ol) ol_c = c;
      chk("done", o_done, ol_c >= 0 && c == ol_c + 1);
      if (ol_c >= 0 && c == ol_c + 1) fin = 1;
      cr_m = cr_m - int'(o_issue) + int'(ret_prev);
      if (c == starve_c) chk("starve_issues", k, CR);
      i_start = (c == 2);
      ret = c >= ret_start && cr_m < CR &&
            (ret_mode == 0 || $urandom_range(0, 1) == 1);
      i_credit_ret = ret;
      ret_prev = ret;
      drive_heads(c + 1 >= b_hold);
    end
    i_start = 1'b0;
    chk("pass_done", fin, 1);
    chk("issue_count", k, n);
    if (b_hold > 0) chk("hold_wait", first_iss >= b_hold, 1);
    if (starve_c >= 0) chk("resume", resume, starve_c + 1);
    @(posedge clk); #1;
    cr_m = cr_m + int'(ret_prev);
    i_credit_ret = 1'b0;
    ret_prev = 1'b0;
    chk("idle_busy", o_busy, 0);
    chk("idle_done", o_done, 0);
    chk("err_state", o_err, err_m);
  endtask

  initial begin
    int cyc;
    do_reset();
    chk("rst_outs", {o_a_deq, o_b_deq, o_sel, o_issue, o_stall, o_sw,
        o_out_valid, o_out_last, o_busy, o_done, o_err}, 0);
    chk("rst_perf_iss", o_perf_issued, 0);
    chk("rst_perf_stl", o_perf_stall, 0);

    qa = '{3, 9}; qb = '{5, 7};
    run_pass(1, 0, 0, -1);

    qa = '{4}; qb = '{4};
    run_pass(1, 0, 0, -1);

    gen(3, 3);
    run_pass(1, 0, 5, -1);

    for (int r = 0; r < 5; r++) begin
      gen($urandom_range(1, 6), $urandom_range(1, 6));
      run_pass(1, 0, 0, -1);
    end

    gen(3, 3);
    ai = 0; bi = 0;
    i_start = 1'b1;
    drive_heads(1'b1);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      i_start = 1'b0;
      cyc++;
    end while (!o_issue && cyc < 20);
    chk("mid_issue_seen", o_issue, 1);
    i_rst = 1'b1;
    #1;
    chk("mid_rst_outs", {o_a_deq, o_b_deq, o_sel, o_issue, o_stall, o_sw,
        o_out_valid, o_out_last, o_busy, o_done, o_err}, 0);
    @(posedge clk); #1;
    i_rst = 1'b0;
    cr_m = CR; ret_prev = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      chk("post_rst_quiet", {o_out_valid, o_out_last, o_done, o_busy}, 0);
    end

    gen(6, 6);
    run_pass(0, 30, 0, 30);

    gen(6, 5);
    run_pass(0, 0, 0, -1);

    chk("pre_ovf_credit", cr_m, CR);
    i_credit_ret = 1'b1;
    @(posedge clk); #1;
    i_credit_ret = 1'b0;
    err_m = 1'b1;
    chk("ovf_err", o_err, 1);
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      chk("ovf_sticky", o_err, 1);
    end
    gen(2, 2);
    run_pass(1, 0, 0, -1);
    do_reset();
    chk("ovf_cleared", o_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/bitonic_merge_ctrl.md
Name: bitonic_merge_ctrl

Overview:
- Sequencer for one bitonic merge node. Two pre-sorted input tuple streams, A and B, are merged here into one sorted stream.
- Each cycle it picks which head tuple enters the bitonic network and pops that source FIFO.
- Gates issue on downstream credits, flags source changes on the switch_output side-band, and tracks in-flight tuples through the NET_LAT-deep network so it can mark the last output and signal completion.

Parameters:
- W, 32, element width in bits.
- NET_LAT, 2, pipeline depth of the driven bitonic network in cycles (2 for a 4-element network).
- CREDITS, 8, downstream FIFO slots available after reset.
- CW, 4, credit counter width; must satisfy 2^CW > CREDITS.

Ports:
- i_clk  in  1  clock; all flops are rising-edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_start  in  1  begin a merge pass; accepted only in IDLE.
- i_a_valid  in  1  head tuple of A is present.
- i_a_last  in  1  head tuple of A is the final tuple of stream A.
- i_a_top  in  W  largest element of A's head tuple.
- o_a_deq  out  1  pop A this cycle; asserted only together with i_a_valid.
- i_b_valid, i_b_last, i_b_top, o_b_deq: identical set for stream B.
- o_sel  out  1  source of the issued tuple: 0 = A, 1 = B.
- o_issue  out  1  a tuple enters the network this cycle.
- o_stall  out  1  asserted in MERGE/DRAIN_A/DRAIN_B whenever o_issue = 0.
- o_switch_output  out  1  this issue's source differs from the previous issue's source.
- i_credit_ret  in  1  downstream freed one slot.
- o_out_valid  out  1  network output is valid; equals o_issue delayed by NET_LAT cycles.
- o_out_last  out  1  the valid network output is the final tuple of the pass.
- o_busy  out  1  FSM is not in IDLE.
- o_done  out  1  one-cycle pulse when the pass completes.
- o_err  out  1  sticky credit-overflow flag.

Behaviour:
- Reset:
  - FSM goes to IDLE; credit counter loads CREDITS; the valid/last delay pipe is cleared.
  - Previous-source register is 0; a_fin and b_fin are 0.
  - Every output is 0.
  - Reset asserted mid-pass drops in-flight tracking. No o_done or o_out_last is produced for the aborted pass.
- All outputs except o_out_valid and o_out_last are registered on the same edge that updates the FSM and credits. o_out_valid and o_out_last come out of the pipe exactly NET_LAT cycles after the matching o_issue.
- States: IDLE, MERGE, DRAIN_A, DRAIN_B, FLUSH.
  - IDLE -> MERGE when i_start = 1. a_fin and b_fin clear.
  - MERGE, choice rule:
    - If both sources are valid, choose the smaller top; on a tie choose A.
    - If only one source is valid, wait. Never issue from one side without comparing.
  - Issue happens when credit > 0 and the chosen source is valid. Issue asserts the matching deq, o_issue and o_sel, and decrements credit.
  - Issuing A's last tuple sets a_fin and moves to DRAIN_B; issuing B's last tuple sets b_fin and moves to DRAIN_A.
  - DRAIN_x: issue from source x whenever it is valid and credit > 0. Issuing x's last tuple moves to FLUSH, and that tuple's pipe entry is tagged last.
  - FLUSH: no issue. When the pipe is empty and o_out_last has been emitted, pulse o_done for one cycle and return to IDLE.
- Credits:
  - Issue alone decrements; i_credit_ret alone increments; both in the same cycle leave the count unchanged.
  - i_credit_ret while the count equals CREDITS and no issue occurs leaves the count at CREDITS and sets o_err. o_err clears only on reset.
- o_switch_output is 1 on an issue when o_sel differs from the previous issued source. The first issue of a pass compares against 0.
- o_stall is 0 in IDLE and FLUSH.
- i_start outside IDLE is ignored.
- Pass end: o_out_last coincides with o_out_valid for the tagged tuple; o_done is asserted in the cycle immediately after.

Optional Feature:
- Macro BITONIC_MERGE_CTRL_PERF_EN.
- Defined:
  - Adds 32-bit outputs o_perf_issued, which counts issues, and o_perf_stall, which counts o_stall cycles.
  - Both clear on reset and on IDLE -> MERGE, and saturate at 0xFFFFFFFF.
- Undefined: both ports remain and are tied to 0. No counter logic is synthesized.

Test Plan:
- Basic merge, CREDITS=8, credit_ret idle:
  - Stimulus: start; A tops 3, 9 (9 last); B tops 5, 7 (7 last); both always valid.
  - Required: issue order A, B, B, A; o_switch_output 0, 1, 0, 1.
  - Required: o_out_last at cycle issue4 + 2; o_done the cycle after.
- Tie: A top = B top = 4. Required: A chosen, o_sel = 0.
- Credit starvation, CREDITS=2:
  - Stimulus: 4 tuples per side; no credit_ret until cycle 10, then one credit per cycle.
  - Required: exactly 2 issues; o_stall = 1 through cycle 10; issue resumes the cycle after the first return.
- Simultaneous issue and credit_ret every cycle: credit count holds at its value throughout.
- Overflow: credit_ret with count = CREDITS and no issue. Required: o_err = 1 and stays 1 until i_rst.
- Reset mid-pass: assert i_rst while 1 tuple is in flight. Required: all outputs 0 immediately, credit = CREDITS, no o_done; a following start runs a clean pass.
